nvram_upload_server: RTL



---
 rtl/nvram_upload_server.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nvram_upload_server.sv
// nvram_upload_server: serves NVRAM bytes to the data_io upload path
// (ioctl_index 8'hFF). It fetches each byte that data_io requests from a
// read port with RD_LAT clocks of latency and holds it stable on
// o_ioctl_din. Optional feature macro: NVRAM_DIRTY_EN. When it is defined,
// o_nvram_dirty tracks game writes since the last save or restore. When it
// is undefined, o_nvram_dirty is tied low.
module nvram_upload_server #(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic              i_ioctl_upload,
  input  logic [7:0]        i_ioctl_index,
  input  logic [24:0]       i_ioctl_addr,
  output logic [7:0]        o_ioctl_din,
  output logic              o_din_valid,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd,
  input  logic [7:0]        i_ram_q,
  output logic              o_game_hold,
  input  logic              i_game_we,
  input  logic              i_restore_wr,
  output logic              o_nvram_dirty
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_READY} state_t;

  localparam logic [1:0] LP_LAT = 2'(RD_LAT);

  state_t              r_state;
  logic [7:0]          r_ioctl_din;
  logic                r_din_valid;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_rd;
  logic                r_game_hold;
  logic                r_pend;
  logic [1:0]          r_cnt;
  logic [24:0]         r_lat_addr;

  logic w_active;
  logic w_in_range;
  logic w_addr_chg;
  logic w_pend;
  logic w_wait_done;

  assign w_active    = i_ioctl_upload && (i_ioctl_index == 8'hFF);
  assign w_in_range  = (i_ioctl_addr >> ADDR_W) == 25'd0;
  assign w_addr_chg  = i_ioctl_addr != r_lat_addr;
  // A change seen on the very clock the wait expires also forces a refetch.
  assign w_pend      = r_pend | w_addr_chg;
  assign w_wait_done = r_cnt == LP_LAT;

  // Fetch FSM: sequences read strobes and loads the presented byte.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ioctl_din <= 8'hFF;
      r_din_valid <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_rd    <= 1'b0;
      r_game_hold <= 1'b0;
      r_pend      <= 1'b0;
      r_cnt       <= 2'd0;
      r_lat_addr  <= 25'd0;
    end else begin
      r_ram_rd <= 1'b0;
      if (!w_active) begin
        // Exit from any state; o_ioctl_din keeps its last value.
        r_state     <= S_IDLE;
        r_din_valid <= 1'b0;
        r_game_hold <= 1'b0;
        r_pend      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_FETCH;
            r_game_hold <= 1'b1;
          end
          S_FETCH: begin
            r_lat_addr <= i_ioctl_addr;
            r_pend     <= 1'b0;
            if (w_in_range) begin
              r_ram_addr <= i_ioctl_addr[ADDR_W-1:0];
              r_ram_rd   <= 1'b1;
              r_cnt      <= 2'd0;
              r_state    <= S_WAIT;
            end else begin
              // Beyond the NVRAM: answer 8'hFF without touching the RAM.
              r_ioctl_din <= 8'hFF;
              r_din_valid <= 1'b1;
              r_state     <= S_READY;
            end
          end
          S_WAIT: begin
            if (w_wait_done) begin
              if (w_pend) begin
                // Stale byte: drop it and fetch the new address.
                r_pend  <= 1'b0;
                r_state <= S_FETCH;
              end else begin
                r_ioctl_din <= i_ram_q;
                r_din_valid <= 1'b1;
                r_state     <= S_READY;
              end
            end else begin
              r_cnt  <= r_cnt + 2'd1;
              r_pend <= w_pend;
            end
          end
          S_READY: begin
            if (w_addr_chg) begin
              r_din_valid <= 1'b0;
              r_state     <= S_FETCH;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ioctl_din = r_ioctl_din;
  assign o_din_valid = r_din_valid;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_rd    = r_ram_rd;
  assign o_game_hold = r_game_hold;

`ifdef NVRAM_DIRTY_EN
  localparam logic [24:0] LP_LAST_ADDR = 25'((1 << ADDR_W) - 1);

  logic r_nvram_dirty;
  logic r_last_seen;
  logic w_load_last;
  logic w_save_done;

  assign w_load_last = (r_state == S_WAIT) && w_wait_done && !w_pend &&
                       w_active && (r_lat_addr == LP_LAST_ADDR);
  assign w_save_done = r_last_seen && !w_active && (r_state != S_IDLE);

  // Dirty tracking: game writes set it; restore or a completed save clear it.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_nvram_dirty <= 1'b0;
      r_last_seen   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_active) begin
        r_last_seen <= 1'b0;
      end else if (w_load_last) begin
        r_last_seen <= 1'b1;
      end
      if (i_restore_wr || w_save_done) begin
        r_nvram_dirty <= 1'b0;
      end
      // Game write has priority over any clear on the same clock.
      if (i_game_we) begin
        r_nvram_dirty <= 1'b1;
      end
    end
  end

  assign o_nvram_dirty = r_nvram_dirty;
`else
  logic w_unused_dirty;
  assign w_unused_dirty = i_game_we ^ i_restore_wr;
  assign o_nvram_dirty  = 1'b0;
`endif

endmodule
